// File: rtl/w5300_cmd_seq.sv
// Command sequencer feeding the W5300 bus interface: issues single/burst register accesses on the
// interface idle strobe and pads empty slots with dummy reads. Optional watchdog: W5300_SEQ_TIMEOUT_EN.
module w5300_cmd_seq #(
    parameter logic        OP_WR_BIT      = 1'b1,
    parameter logic [9:0]  IDLE_ADDR      = 10'h000,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd8192
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [9:0]  req_addr,
    input  logic [7:0]  req_len,
    input  logic        req_incr,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [15:0] wr_data,
    output logic        rd_valid,
    output logic [15:0] rd_data,
    output logic        rd_last,
    output logic        done,
    output logic        busy,
    output logic        err_timeout,
    output logic [10:0] ctrl_addr,
    output logic [15:0] ctrl_wr_data,
    input  logic [15:0] ctrl_rd_data,
    input  logic        ctrl_op_state
);

    typedef enum logic [1:0] {S_IDLE, S_BURST, S_DRAIN} state_t;
    typedef enum logic [1:0] {K_NONE, K_DUMMY, K_WRITE, K_READ} kind_t;

    localparam logic [10:0] DUMMY_OP = {~OP_WR_BIT, IDLE_ADDR};

    state_t      state_reg, state_next;
    kind_t       kind_reg, kind_next;
    logic        last_reg, last_next;
    logic        op_write_reg;
    logic        incr_reg;
    logic [9:0]  addr_reg;
    logic [8:0]  words_left_reg;
    logic [10:0] exec_addr_reg, addr_next;
    logic [15:0] exec_data_reg, data_next;
    logic        real_op;
    logic        req_ready_reg;
    logic        rd_valid_reg;
    logic        rd_last_reg;
    logic [15:0] rd_data_reg;
    logic        done_reg;
    logic        timeout_hit;
    logic        issue;
    logic        accept;

    assign issue  = ctrl_op_state;
    assign accept = req_valid & req_ready_reg;

    // Op to launch if this cycle turns out to be an issue cycle
    always_comb begin
        addr_next = DUMMY_OP;
        data_next = 16'h0000;
        kind_next = K_DUMMY;
        last_next = 1'b0;
        real_op   = 1'b0;
        if (state_reg == S_BURST && words_left_reg != 9'd0 && (!op_write_reg || wr_valid)) begin
            real_op   = 1'b1;
            addr_next = {(op_write_reg ? OP_WR_BIT : ~OP_WR_BIT), addr_reg};
            data_next = op_write_reg ? wr_data : 16'h0000;
            kind_next = op_write_reg ? K_WRITE : K_READ;
            last_next = (words_left_reg == 9'd1);
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (accept) state_next = S_BURST;
            S_BURST: if (issue && real_op && words_left_reg == 9'd1) state_next = S_DRAIN;
            S_DRAIN: if (issue) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        if (timeout_hit) state_next = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= S_IDLE;
            kind_reg       <= K_NONE;
            last_reg       <= 1'b0;
            op_write_reg   <= 1'b0;
            incr_reg       <= 1'b0;
            addr_reg       <= 10'h000;
            words_left_reg <= 9'd0;
            exec_addr_reg  <= DUMMY_OP;
            exec_data_reg  <= 16'h0000;
            req_ready_reg  <= 1'b0;
            rd_valid_reg   <= 1'b0;
            rd_last_reg    <= 1'b0;
            rd_data_reg    <= 16'h0000;
            done_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            // Ready only after a full cycle in idle, so it never overlaps the done pulse
            req_ready_reg <= (state_reg == S_IDLE) && (state_next == S_IDLE);
            rd_valid_reg  <= 1'b0;
            rd_last_reg   <= 1'b0;
            done_reg      <= 1'b0;

            if (accept) begin
                op_write_reg   <= req_write;
                addr_reg       <= req_addr;
                incr_reg       <= req_incr;
                words_left_reg <= {1'b0, req_len} + 9'd1;
            end

            if (issue) begin
                exec_addr_reg <= addr_next;
                exec_data_reg <= data_next;
                kind_reg      <= kind_next;
                last_reg      <= last_next;
                // ctrl_rd_data belongs to the op that is completing now
                if (kind_reg == K_READ) begin
                    rd_valid_reg <= 1'b1;
                    rd_data_reg  <= ctrl_rd_data;
                    rd_last_reg  <= last_reg;
                end
                if (state_reg == S_DRAIN) done_reg <= 1'b1;
                if (real_op) begin
                    words_left_reg <= words_left_reg - 9'd1;
                    if (incr_reg) addr_reg <= addr_reg + 10'd2;
                end
            end

            if (timeout_hit) begin
                exec_addr_reg <= DUMMY_OP;
                exec_data_reg <= 16'h0000;
                kind_reg      <= K_NONE;
                last_reg      <= 1'b0;
            end
        end
    end

`ifdef W5300_SEQ_TIMEOUT_EN
    logic [15:0] to_cnt_reg;
    logic        err_timeout_reg;

    assign timeout_hit = (state_reg != S_IDLE) && !issue && (to_cnt_reg == TIMEOUT_CYCLES - 16'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_reg      <= 16'd0;
            err_timeout_reg <= 1'b0;
        end else begin
            err_timeout_reg <= timeout_hit;
            if (state_reg == S_IDLE || issue) to_cnt_reg <= 16'd0;
            else                              to_cnt_reg <= to_cnt_reg + 16'd1;
        end
    end

    assign err_timeout = err_timeout_reg;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign timeout_hit    = 1'b0;
    assign err_timeout    = 1'b0;
`endif

    assign req_ready    = req_ready_reg;
    assign wr_ready     = issue && (state_reg == S_BURST) && op_write_reg && (words_left_reg != 9'd0);
    assign rd_valid     = rd_valid_reg;
    assign rd_data      = rd_data_reg;
    assign rd_last      = rd_last_reg;
    assign done         = done_reg;
    assign busy         = (state_reg != S_IDLE);
    assign ctrl_addr    = issue ? addr_next : exec_addr_reg;
    assign ctrl_wr_data = issue ? data_next : exec_data_reg;

endmodule

// File: tb/tb_w5300_cmd_seq.sv
// Scoreboard bench for w5300_cmd_seq: a 1+6 cycle interface model, a register-file reference
// model filled at request time, and a negedge monitor that checks every issue and output pulse.
module tb_w5300_cmd_seq;

    localparam logic [10:0] DUMMY_OP = 11'h000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [9:0]  req_addr = 10'h000;
    logic [7:0]  req_len = 8'h00;
    logic        req_incr = 1'b0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [15:0] wr_data = 16'h0000;
    logic        rd_valid;
    logic [15:0] rd_data;
    logic        rd_last;
    logic        done;
    logic        busy;
    logic        err_timeout;
    logic [10:0] ctrl_addr;
    logic [15:0] ctrl_wr_data;
    logic [15:0] ctrl_rd_data = 16'h0000;
    logic        ctrl_op_state = 1'b0;

    w5300_cmd_seq dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_len(req_len), .req_incr(req_incr),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last),
        .done(done), .busy(busy), .err_timeout(err_timeout),
        .ctrl_addr(ctrl_addr), .ctrl_wr_data(ctrl_wr_data),
        .ctrl_rd_data(ctrl_rd_data), .ctrl_op_state(ctrl_op_state)
    );

    always #5 clk = ~clk;

    typedef struct { logic wr; logic [9:0] addr; logic [15:0] data; logic last; } op_t;
    typedef struct { logic [15:0] data; logic last; } rd_t;

    op_t         exp_ops[$];
    rd_t         exp_rds[$];
    logic        exp_done[$];
    logic [15:0] wr_q[$];
    logic [15:0] ref_mem[1024];
    logic [15:0] bus_mem[1024];

    int checks = 0, passes = 0;
    int cyc = 0, acc_cyc = 0, done_cyc = 0;
    int real_issues = 0, burst_dummies = 0, wr_hs = 0, rd_count = 0, timeouts = 0;
    int wr_block = 0, phase = 0;
    logic wr_always = 1'b0, if_hold = 1'b0, outstanding = 1'b0;
    logic rd_due = 1'b0, done_due = 1'b0, prev_read = 1'b0, last_pending = 1'b0;
    logic [10:0] hold_addr = DUMMY_OP;
    logic [15:0] hold_data = 16'h0, last_rd = 16'h0, pending_rd = 16'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic flush_model();
        exp_ops.delete(); exp_rds.delete(); exp_done.delete(); wr_q.delete();
        outstanding = 1'b0; rd_due = 1'b0; done_due = 1'b0; prev_read = 1'b0; last_pending = 1'b0;
        hold_addr = DUMMY_OP; hold_data = 16'h0;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Interface model: one idle (issue) cycle followed by six op cycles
    always @(posedge clk) begin
        #1;
        if (if_hold) ctrl_op_state = 1'b0;
        else begin
            phase = (phase == 6) ? 0 : phase + 1;
            ctrl_op_state = (phase == 0);
        end
        ctrl_rd_data = ctrl_op_state ? pending_rd : 16'($urandom);
    end

    // Write-word source
    always @(posedge clk) begin
        #1;
        if (wr_block > 0) begin wr_block--; wr_valid = 1'b0; end
        else if (wr_q.size() > 0) wr_valid = wr_always ? 1'b1 : ($urandom_range(0, 3) != 0);
        else wr_valid = 1'b0;
        wr_data = wr_valid ? wr_q[0] : 16'($urandom);
    end

    // Monitor / scoreboard
    always @(negedge clk) begin
        logic        exp_real;
        logic [10:0] e_addr;
        logic [15:0] e_data;
        op_t         op;
        rd_t         r;
        logic        is_rd;
        if (!rst_n) begin
            check("reset_outputs", {req_ready, wr_ready, rd_valid, rd_last, done, busy, err_timeout, rd_data}, 32'h0);
            flush_model();
            last_rd = 16'h0;
        end else begin
            if (err_timeout) begin timeouts++; flush_model(); end
`ifndef W5300_SEQ_TIMEOUT_EN
            check("err_timeout_low", err_timeout, 1'b0);
`endif
            check("rd_valid_timing", rd_valid, rd_due);
            check("done_timing", done, done_due);
            if (rd_valid) begin
                rd_count++;
                if (exp_rds.size() == 0) check("rd_unexpected", rd_valid, 1'b0);
                else begin
                    r = exp_rds.pop_front();
                    check("rd_data", rd_data, r.data);
                    check("rd_last", rd_last, r.last);
                    last_rd = r.data;
                end
            end else begin
                check("rd_data_hold", rd_data, last_rd);
                check("rd_last_idle", rd_last, 1'b0);
            end
            if (done) begin
                done_cyc = cyc;
                if (exp_done.size() == 0) check("done_unexpected", done, 1'b0);
                else begin
                    is_rd = exp_done.pop_front();
                    check("done_with_last_rd", {rd_valid, rd_last}, {is_rd, is_rd});
                end
                outstanding = 1'b0;
            end
            check("busy", busy, outstanding);
            if (outstanding) check("ready_while_busy", req_ready, 1'b0);
            check("wr_ready", wr_ready, ctrl_op_state && exp_ops.size() > 0 && exp_ops[0].wr);

            rd_due = 1'b0;
            done_due = 1'b0;
            if (ctrl_op_state) begin
                rd_due = prev_read;
                done_due = last_pending;
                prev_read = 1'b0;
                last_pending = 1'b0;
                exp_real = exp_ops.size() > 0 && (!exp_ops[0].wr || wr_valid);
                e_addr = DUMMY_OP;
                e_data = 16'h0;
                if (exp_real) begin
                    e_addr = {exp_ops[0].wr, exp_ops[0].addr};
                    e_data = exp_ops[0].wr ? exp_ops[0].data : 16'h0;
                end
                check("issue_addr", ctrl_addr, e_addr);
                check("issue_data", ctrl_wr_data, e_data);
                if (exp_real) begin
                    op = exp_ops.pop_front();
                    real_issues++;
                    prev_read = !op.wr;
                    last_pending = op.last;
                end else if (exp_ops.size() > 0) burst_dummies++;
                if (ctrl_addr[10]) bus_mem[ctrl_addr[9:0]] = ctrl_wr_data;
                else pending_rd = bus_mem[ctrl_addr[9:0]];
                if (wr_ready && wr_valid) begin
                    wr_hs++;
                    if (wr_q.size() > 0) void'(wr_q.pop_front());
                end
                hold_addr = ctrl_addr;
                hold_data = ctrl_wr_data;
            end else begin
                check("stable_addr", ctrl_addr, hold_addr);
                check("stable_data", ctrl_wr_data, hold_data);
            end
        end
    end

    task automatic do_req(input logic wr, input logic [9:0] addr, input logic [7:0] len,
                          input logic incr, input int fixed, input int block);
        int n;
        logic [9:0] a;
        logic [15:0] w;
        @(posedge clk); #1;
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_len = len; req_incr = incr;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 5000) begin @(negedge clk); n++; end
        check("req_accept", req_ready, 1'b1);
        if (!req_ready) begin req_valid = 1'b0; return; end
        acc_cyc = cyc;
        wr_block = block;
        @(posedge clk); #1;
        req_valid = 1'b0; req_write = 1'($urandom); req_addr = 10'($urandom); req_len = 8'($urandom);
        for (int i = 0; i <= int'(len); i++) begin
            a = incr ? 10'((int'(addr) + 2 * i) % 1024) : addr;
            if (wr) begin
                w = (fixed >= 0 && i == 0) ? 16'(fixed) : 16'($urandom);
                exp_ops.push_back('{1'b1, a, w, i == int'(len)});
                wr_q.push_back(w);
                ref_mem[a] = w;
            end else begin
                exp_ops.push_back('{1'b0, a, 16'h0, i == int'(len)});
                exp_rds.push_back('{ref_mem[a], i == int'(len)});
            end
        end
        exp_done.push_back(!wr);
        outstanding = 1'b1;
        burst_dummies = 0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (outstanding && n < budget) begin @(posedge clk); n++; end
        @(negedge clk);
        check("done_wait", outstanding, 1'b0);
    endtask

    initial begin
        int base, hs0, rd0;
        for (int i = 0; i < 1024; i++) begin
            ref_mem[i] = 16'($urandom);
            bus_mem[i] = ref_mem[i];
        end
        ref_mem[10'h3FC] = 16'h1111; ref_mem[10'h3FE] = 16'h2222;
        ref_mem[10'h000] = 16'h3333; ref_mem[10'h002] = 16'h4444;
        bus_mem[10'h3FC] = 16'h1111; bus_mem[10'h3FE] = 16'h2222;
        bus_mem[10'h000] = 16'h3333; bus_mem[10'h002] = 16'h4444;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b1;

        // Single write
        do_req(1'b1, 10'h200, 8'd0, 1'b0, 16'hA5A5, 0);
        wait_done(500);

        // Incrementing read across the top of the address space
        rd0 = rd_count;
        do_req(1'b0, 10'h3FC, 8'd3, 1'b1, -1, 0);
        wait_done(500);
        check("incr_read_words", rd_count - rd0, 4);

        // Fixed-address write with one starved issue slot
        wr_always = 1'b1;
        hs0 = wr_hs;
        do_req(1'b1, 10'h22E, 8'd2, 1'b0, -1, 7);
        wait_done(500);
        check("starve_dummies", burst_dummies, 1);
        check("starve_handshakes", wr_hs - hs0, 3);
        wr_always = 1'b0;

        // Request held while busy: accepted the cycle after done
        do_req(1'b0, 10'h010, 8'd3, 1'b1, -1, 0);
        do_req(1'b1, 10'h040, 8'd1, 1'b1, -1, 0);
        check("accept_after_done", acc_cyc, done_cyc + 1);
        wait_done(500);

        // Reset during the second op of a read burst
        base = real_issues;
        do_req(1'b0, 10'h120, 8'd3, 1'b1, -1, 0);
        for (int n = 0; n < 200 && real_issues < base + 2; n++) @(posedge clk);
        check("reset_wait", real_issues >= base + 2, 1'b1);
        @(posedge clk); #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (10) @(posedge clk);
        do_req(1'b0, 10'h0F0, 8'd0, 1'b0, -1, 0);
        wait_done(500);

        // Randomised traffic, plus one maximum-length FIFO read
        for (int k = 0; k < 30; k++) begin
            do_req(1'($urandom), 10'($urandom), 8'($urandom_range(0, 7)), 1'($urandom), -1, 0);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 20)) @(posedge clk);
        end
        do_req(1'b0, 10'h1F0, 8'd255, 1'b0, -1, 0);
        wait_done(5000);

        // Interface held in reset while a request is pending
        if_hold = 1'b1;
        do_req(1'b0, 10'h300, 8'd0, 1'b0, -1, 0);
`ifdef W5300_SEQ_TIMEOUT_EN
        for (int n = 0; n < 8400 && timeouts == 0; n++) @(posedge clk);
        @(negedge clk);
        check("timeout_pulse", timeouts, 1);
        check("timeout_busy", busy, 1'b0);
        if_hold = 1'b0;
`else
        repeat (8400) @(posedge clk);
        @(negedge clk);
        check("hold_busy", busy, 1'b1);
        check("hold_err", err_timeout, 1'b0);
        if_hold = 1'b0;
        wait_done(500);
`endif
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("left_ops", exp_ops.size(), 0);
        check("left_rds", exp_rds.size(), 0);
        check("left_done", exp_done.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
